pad_alsaqr_rx_filter: RTL and testbench

PAD_ALSAQR_RX_FILTER -- requirements
Module: pad_alsaqr_rx_filter

---
 rtl/pad_rx_pkg.sv | 21 ++
 rtl/pad_rx_evt_fifo.sv | 60 ++++++
 rtl/pad_alsaqr_rx_filter.sv | 156 +++++++++++++++
 tb/tb_pad_alsaqr_rx_filter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_rx_pkg.sv
// Shared types and constants for the pad receive filter: filter states,
// edge-select bit positions, the queued event type and the default queue depth.
package pad_rx_pkg;

  typedef enum logic [1:0] {
    STB_LO = 2'd0,
    PND_HI = 2'd1,
    STB_HI = 2'd2,
    PND_LO = 2'd3
  } filt_state_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;

  typedef struct packed {
    logic rise;
  } pad_evt_t;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/pad_rx_evt_fifo.sv
// Small event queue for filtered pad edges. A push into a full queue is taken
// only when a pop happens in the same cycle; popping an empty queue does nothing.
module pad_rx_evt_fifo
  import pad_rx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  pad_evt_t push_data_i,
  input  logic     pop_i,
  output pad_evt_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  pad_evt_t           mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_pop_s;
  logic               do_push_s;

  assign empty_o    = (count_r == {CNT_W{1'b0}});
  assign full_o     = (count_r == FULL_CNT);
  assign do_pop_s   = pop_i & ~empty_o;
  assign do_push_s  = push_i & (~full_o | do_pop_s);
  assign pop_data_o = empty_o ? pad_evt_t'(1'b0) : mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= pad_evt_t'(1'b0);
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pad_alsaqr_rx_filter.sv
// Pad receive path: synchronizer, glitch filter FSM and edge-event queue.
// Define PAD_RX_SYNC3_EN to add a third synchronizer stage.
module pad_alsaqr_rx_filter
  import pad_rx_pkg::*;
#(
  parameter logic        RST_LEVEL  = 1'b0,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pad_o_i,
  input  logic [7:0] filt_len_i,
  input  logic [1:0] edge_sel_i,
  output logic       data_o,
  output logic       evt_valid_o,
  output logic       evt_rise_o,
  input  logic       evt_ready_i,
  output logic       ovf_o,
  input  logic       ovf_clr_i
);

`ifdef PAD_RX_SYNC3_EN
  localparam int unsigned SYNC_STAGES = 3;
`else
  localparam int unsigned SYNC_STAGES = 2;
`endif

  localparam filt_state_e RST_STATE = RST_LEVEL ? STB_HI : STB_LO;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  filt_state_e            state_r;
  filt_state_e            state_n_s;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_n_s;
  logic                   data_n_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   drop_s;
  pad_evt_t               push_evt_s;
  pad_evt_t               head_evt_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Filter next state: leave a stable state on a mismatch, commit once s has held long enough.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      STB_LO: begin
        if (s_s) begin
          if (filt_len_i == 8'd0) begin
            state_n_s = STB_HI;
          end else begin
            state_n_s = PND_HI;
            cnt_n_s   = 8'd1;
          end
        end else begin
          state_n_s = STB_LO;
        end
      end
      PND_HI: begin
        if (!s_s) begin
          state_n_s = STB_LO;
          cnt_n_s   = 8'd0;
        end else if (cnt_r >= filt_len_i) begin
          state_n_s = STB_HI;
          cnt_n_s   = 8'd0;
        end else begin
          cnt_n_s = cnt_r + 8'd1;
        end
      end
      STB_HI: begin
        if (!s_s) begin
          if (filt_len_i == 8'd0) begin
            state_n_s = STB_LO;
          end else begin
            state_n_s = PND_LO;
            cnt_n_s   = 8'd1;
          end
        end else begin
          state_n_s = STB_HI;
        end
      end
      PND_LO: begin
        if (s_s) begin
          state_n_s = STB_HI;
          cnt_n_s   = 8'd0;
        end else if (cnt_r >= filt_len_i) begin
          state_n_s = STB_LO;
          cnt_n_s   = 8'd0;
        end else begin
          cnt_n_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_n_s = RST_STATE;
        cnt_n_s   = 8'd0;
      end
    endcase
  end

  assign data_n_s        = (state_n_s == STB_HI) || (state_n_s == PND_LO);
  assign push_s          = (data_n_s & ~data_o & edge_sel_i[EDGE_RISE])
                         | (~data_n_s & data_o & edge_sel_i[EDGE_FALL]);
  assign push_evt_s.rise = data_n_s;
  assign pop_s           = evt_valid_o & evt_ready_i;
  assign drop_s          = push_s & full_s & ~pop_s;

  // Synchronizer, filter state and the registered level output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r  <= {SYNC_STAGES{RST_LEVEL}};
      state_r <= RST_STATE;
      cnt_r   <= 8'd0;
      data_o  <= RST_LEVEL;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], pad_o_i};
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      data_o  <= data_n_s;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (drop_s) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end else begin
      ovf_o <= ovf_o;
    end
  end

  pad_rx_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (push_evt_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_evt_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  assign evt_valid_o = ~empty_s;
  assign evt_rise_o  = head_evt_s.rise;

endmodule

// File: tb/tb_pad_alsaqr_rx_filter.sv
// Directed bench for pad_alsaqr_rx_filter; honours PAD_RX_SYNC3_EN for latency.
module tb_pad_alsaqr_rx_filter;

`ifdef PAD_RX_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pad_o_i = 1'b0;
  logic [7:0] filt_len_i = 8'd0;
  logic [1:0] edge_sel_i = 2'b11;
  logic       data_o;
  logic       evt_valid_o;
  logic       evt_rise_o;
  logic       evt_ready_i = 1'b0;
  logic       ovf_o;
  logic       ovf_clr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  pad_alsaqr_rx_filter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pad_o_i     (pad_o_i),
    .filt_len_i  (filt_len_i),
    .edge_sel_i  (edge_sel_i),
    .data_o      (data_o),
    .evt_valid_o (evt_valid_o),
    .evt_rise_o  (evt_rise_o),
    .evt_ready_i (evt_ready_i),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    pad_o_i = 1'b0;
    evt_ready_i = 1'b0;
    ovf_clr_i = 1'b0;
    cyc(2);
    rst_i = 1'b0;
  endtask

  task automatic pop1();
    evt_ready_i = 1'b1;
    cyc(1);
    evt_ready_i = 1'b0;
  endtask

  initial begin
    logic seen_hi;
    cyc(3);
    // reset values
    chk("rst_data", data_o, 8'd0);
    chk("rst_valid", evt_valid_o, 8'd0);
    chk("rst_rise", evt_rise_o, 8'd0);
    chk("rst_ovf", ovf_o, 8'd0);
    rst_i = 1'b0;
    cyc(2);

    // glitch shorter than the filter is rejected
    filt_len_i = 8'd3;
    edge_sel_i = 2'b11;
    pad_o_i = 1'b1;
    cyc(3);
    pad_o_i = 1'b0;
    seen_hi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      seen_hi = seen_hi | data_o;
    end
    chk("glitch_data", seen_hi, 8'd0);
    chk("glitch_evt", evt_valid_o, 8'd0);

    // latency SYNC+1+N with the rise event visible in the same cycle
    pad_o_i = 1'b1;
    cyc(SYNC + 3);
    chk("lat_before", data_o, 8'd0);
    chk("lat_before_evt", evt_valid_o, 8'd0);
    cyc(1);
    chk("lat_data", data_o, 8'd1);
    chk("lat_valid", evt_valid_o, 8'd1);
    chk("lat_rise", evt_rise_o, 8'd1);
    pop1();
    chk("lat_popped", evt_valid_o, 8'd0);
    pad_o_i = 1'b0;
    cyc(SYNC + 4);
    chk("fall_data", data_o, 8'd0);
    chk("fall_valid", evt_valid_o, 8'd1);
    chk("fall_rise", evt_rise_o, 8'd0);
    pop1();

    // N=0, only falling events enabled
    do_reset();
    filt_len_i = 8'd0;
    edge_sel_i = 2'b10;
    cyc(10);
    pad_o_i = 1'b1;
    cyc(SYNC);
    chk("n0_rise_before", data_o, 8'd0);
    cyc(1);
    chk("n0_rise_data", data_o, 8'd1);
    chk("n0_rise_noevt", evt_valid_o, 8'd0);
    cyc(9 - SYNC);
    pad_o_i = 1'b0;
    cyc(SYNC);
    chk("n0_fall_before", data_o, 8'd1);
    cyc(1);
    chk("n0_fall_data", data_o, 8'd0);
    chk("n0_fall_valid", evt_valid_o, 8'd1);
    chk("n0_fall_rise", evt_rise_o, 8'd0);
    cyc(9 - SYNC);
    pop1();
    chk("n0_one_evt", evt_valid_o, 8'd0);

    // overflow with ready low, then clear
    do_reset();
    edge_sel_i = 2'b11;
    pad_o_i = 1'b1;
    cyc(6);
    pad_o_i = 1'b0;
    cyc(6);
    chk("ovf_not_yet", ovf_o, 8'd0);
    pad_o_i = 1'b1;
    cyc(6);
    chk("ovf_set", ovf_o, 8'd1);
    chk("ovf_head0", evt_rise_o, 8'd1);
    pop1();
    chk("ovf_head1_valid", evt_valid_o, 8'd1);
    chk("ovf_head1", evt_rise_o, 8'd0);
    ovf_clr_i = 1'b1;
    cyc(1);
    ovf_clr_i = 1'b0;
    chk("ovf_clr", ovf_o, 8'd0);
    pop1();
    chk("ovf_drained", evt_valid_o, 8'd0);

    // full queue, pop coincides with the third push
    do_reset();
    pad_o_i = 1'b1;
    cyc(6);
    pad_o_i = 1'b0;
    cyc(6);
    pad_o_i = 1'b1;
    cyc(SYNC);
    evt_ready_i = 1'b1;
    cyc(1);
    evt_ready_i = 1'b0;
    chk("fullpop_ovf", ovf_o, 8'd0);
    chk("fullpop_head", evt_rise_o, 8'd0);
    pop1();
    chk("fullpop_new_valid", evt_valid_o, 8'd1);
    chk("fullpop_new", evt_rise_o, 8'd1);
    pop1();
    chk("fullpop_empty", evt_valid_o, 8'd0);

    // shrinking N mid-pending takes effect immediately
    do_reset();
    filt_len_i = 8'd10;
    edge_sel_i = 2'b00;
    pad_o_i = 1'b1;
    cyc(SYNC + 3);
    chk("nchg_before", data_o, 8'd0);
    filt_len_i = 8'd2;
    cyc(1);
    chk("nchg_data", data_o, 8'd1);

    // reset while pending with a queued event
    do_reset();
    filt_len_i = 8'd5;
    edge_sel_i = 2'b01;
    pad_o_i = 1'b1;
    cyc(SYNC + 7);
    pad_o_i = 1'b0;
    cyc(SYNC + 7);
    chk("rstp_data_lo", data_o, 8'd0);
    pad_o_i = 1'b1;
    cyc(SYNC + 2);
    chk("rstp_queued", evt_valid_o, 8'd1);
    chk("rstp_cnt", dut.cnt_r, 8'd2);
    rst_i = 1'b1;
    cyc(1);
    rst_i = 1'b0;
    chk("rstp_data", data_o, 8'd0);
    chk("rstp_valid", evt_valid_o, 8'd0);
    chk("rstp_cnt0", dut.cnt_r, 8'd0);
    chk("rstp_ovf", ovf_o, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
